// File: rtl/uart_pkg.sv
// Shared definitions for the UART word bridge: command byte layout,
// register addresses, bridge FSM states and the word-to-byte helper.
package uart_pkg;

  localparam logic [2:0] UART_CR_ADDR   = 3'd0;
  localparam logic [2:0] UART_SR_ADDR   = 3'd1;
  localparam logic [2:0] UART_DIN_ADDR  = 3'd2;
  localparam logic [2:0] UART_DOUT_ADDR = 3'd3;

  typedef struct packed {
    logic       wr;
    logic [3:0] rsvd;
    logic [2:0] addr;
  } uart_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    TX      = 2'd2
  } uart_bridge_state_t;

  // Number of UART bytes needed to carry one data_w-bit word.
  function automatic int bytes_of(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO buffering core output words until the host reads them.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write request and word; ignored when full unless popping
//   pop             remove head word; ignored when empty
//   flush           synchronous clear to empty
//   rdata           head word (valid when !empty)
//   full, empty     occupancy flags
module uart_word_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the head slot, which is exactly where
  // wr_ptr points, so the incoming word can take it.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_bridge.sv
// Byte-command bridge between UART RX/TX byte streams and the processing core.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   rx_data, rx_vld        received byte strobe (no backpressure)
//   tx_data, tx_vld, tx_rdy  outgoing byte handshake
//   cr_en, cr_src_sel      control register outputs
//   cr_rst                 1-cycle core reset pulse
//   din_data, din_vld      assembled core input word
//   dout_data, dout_vld    core output words pushed into the FIFO
//   ext_flags              core status flags reported in SR
//
// state   | meaning
// IDLE    | waiting for a command byte
// WR_DATA | collecting data bytes of a CR or DIN write, timeout running
// TX      | sending a CR/SR/DOUT read response, LSB byte first
module uart_word_bridge
  import uart_pkg::*;
#(
  parameter int DATA_W      = 11,
  parameter int DOUT_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int N_EXT       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_vld,
  output logic [7:0]        tx_data,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic              cr_en,
  output logic              cr_src_sel,
  output logic              cr_rst,
  output logic [DATA_W-1:0] din_data,
  output logic              din_vld,
  input  logic [DATA_W-1:0] dout_data,
  input  logic              dout_vld,
  input  logic [N_EXT-1:0]  ext_flags
);

  localparam int              BYTES    = bytes_of(DATA_W);
  localparam logic [1:0]      LAST_IDX = 2'(BYTES - 1);
  localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);

  uart_bridge_state_t state_q, state_d;
  uart_cmd_t          cmd;
  logic [2:0]         addr_q;
  logic [1:0]         byte_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [31:0]        asm_q, asm_nxt;
  logic [31:0]        tx_sr_q;
  logic               tx_pop_q;
  logic               err_q;
  logic               cmd_ok, wr_last, tx_last, tx_acc, to_hit;
  logic               err_set, err_clr;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]  fifo_head;
  logic [N_EXT+2:0]   sr_raw;
  logic [7:0]         sr_byte, cr_byte;

  assign cmd     = uart_cmd_t'(rx_data);
  assign tx_vld  = (state_q == TX);
  assign tx_data = tx_sr_q[7:0];
  assign tx_acc  = tx_vld && tx_rdy;
  assign wr_last = (addr_q == UART_CR_ADDR) || (byte_cnt_q == LAST_IDX);
  assign tx_last = (addr_q != UART_DOUT_ADDR) || (byte_cnt_q == LAST_IDX);
  assign to_hit  = (state_q == WR_DATA) && !rx_vld && (to_cnt_q == '0);
  assign fifo_pop = tx_acc && tx_last && tx_pop_q;

  assign sr_raw  = {fifo_empty, fifo_full, err_q, ext_flags};
  assign sr_byte = 8'(sr_raw);
  assign cr_byte = {6'd0, cr_en, cr_src_sel};

  uart_word_fifo #(.DATA_W(DATA_W), .DEPTH(DOUT_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dout_vld),
    .wdata (dout_data),
    .pop   (fifo_pop),
    .flush (cr_rst),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cmd_ok  = 1'b0;
    asm_nxt = asm_q;
    asm_nxt[{byte_cnt_q, 3'b000} +: 8] = rx_data;
    case (cmd.addr)
      UART_CR_ADDR, UART_SR_ADDR: cmd_ok = 1'b1;
      UART_DIN_ADDR:              cmd_ok = cmd.wr;
      UART_DOUT_ADDR:             cmd_ok = !cmd.wr;
      default:                    cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_clr = cr_rst;
    if (dout_vld && fifo_full && !fifo_pop) err_set = 1'b1;
    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (!cmd_ok) begin
            err_set = 1'b1;
          end else if (cmd.wr) begin
            if (cmd.addr == UART_SR_ADDR) err_clr = 1'b1;
            else                          state_d = WR_DATA;
          end else begin
            state_d = TX;
            if (cmd.addr == UART_DOUT_ADDR && fifo_empty) err_set = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (rx_vld && wr_last) begin
          state_d = IDLE;
        end else if (to_hit) begin
          state_d = IDLE;
          err_set = 1'b1;
        end
      end
      TX: begin
        if (rx_vld) err_set = 1'b1;
        if (tx_acc && tx_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      asm_q      <= '0;
      tx_sr_q    <= '0;
      tx_pop_q   <= 1'b0;
      err_q      <= 1'b0;
      cr_en      <= 1'b0;
      cr_src_sel <= 1'b0;
      cr_rst     <= 1'b0;
      din_data   <= '0;
      din_vld    <= 1'b0;
    end else begin
      state_q <= state_d;
      din_vld <= 1'b0;
      cr_rst  <= 1'b0;
      if (err_clr)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rx_vld) begin
            // Response is snapshotted at command time so later FIFO pushes
            // or flag changes cannot alter bytes already being sent.
            addr_q     <= cmd.addr;
            byte_cnt_q <= '0;
            to_cnt_q   <= TO_LOAD;
            asm_q      <= '0;
            tx_pop_q   <= (cmd.addr == UART_DOUT_ADDR) && !fifo_empty;
            case (cmd.addr)
              UART_CR_ADDR:   tx_sr_q <= 32'(cr_byte);
              UART_SR_ADDR:   tx_sr_q <= 32'(sr_byte);
              UART_DOUT_ADDR: tx_sr_q <= fifo_empty ? 32'd0 : 32'(fifo_head);
              default:        tx_sr_q <= '0;
            endcase
          end
        end
        WR_DATA: begin
          if (rx_vld) begin
            asm_q      <= asm_nxt;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            to_cnt_q   <= TO_LOAD;
            if (wr_last) begin
              if (addr_q == UART_CR_ADDR) begin
                cr_src_sel <= rx_data[0];
                cr_en      <= rx_data[1];
                cr_rst     <= rx_data[2];
              end else begin
                din_data <= asm_nxt[DATA_W-1:0];
                din_vld  <= 1'b1;
              end
            end
          end else if (to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - TO_W'(1);
          end
        end
        TX: begin
          if (tx_acc) begin
            tx_sr_q    <= tx_sr_q >> 8;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
module tb_uart_word_bridge;

  localparam int DATA_W      = 11;
  localparam int DOUT_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int N_EXT       = 5;
  localparam logic [4:0] EXT = 5'h15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_vld = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              tx_rdy = 1'b1;
  logic              cr_en, cr_src_sel, cr_rst;
  logic [DATA_W-1:0] din_data;
  logic              din_vld;
  logic [DATA_W-1:0] dout_data = '0;
  logic              dout_vld = 1'b0;
  logic [N_EXT-1:0]  ext_flags = EXT;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  logic [7:0]        exp_tx[$];
  logic [DATA_W-1:0] exp_din[$];

  uart_word_bridge #(
    .DATA_W(DATA_W), .DOUT_DEPTH(DOUT_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC), .N_EXT(N_EXT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .cr_en(cr_en), .cr_src_sel(cr_src_sel), .cr_rst(cr_rst),
    .din_data(din_data), .din_vld(din_vld),
    .dout_data(dout_data), .dout_vld(dout_vld), .ext_flags(ext_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sr(input logic e, input logic f, input logic er);
    return {e, f, er, EXT};
  endfunction

  // tx_rdy pattern: 0 always ready, 1 random stalls, 2 held off
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = ($urandom_range(0, 2) != 0);
      default: tx_rdy = 1'b0;
    endcase
  end

  // scoreboard: compare each accepted byte / din strobe against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_vld && tx_rdy) begin
        chk("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (din_vld) begin
        chk("din_expected", exp_din.size() != 0, 1);
        if (exp_din.size() != 0) chk("din_data", din_data, exp_din.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_vld = 1'b1;
    @(posedge clk); #1;
    rx_vld = 1'b0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    @(posedge clk); #1;
    dout_data = w; dout_vld = 1'b1;
    @(posedge clk); #1;
    dout_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_tx.size() != 0 && n < 400) begin
      @(negedge clk); n++;
    end
    chk({tag, "_drained"}, exp_tx.size(), 0);
    @(negedge clk);
    chk({tag, "_tx_idle"}, tx_vld, 0);
  endtask

  task automatic read_sr(input string tag, input logic [7:0] v);
    exp_tx.push_back(v);
    send_byte(8'h01);
    drain(tag);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_cr_en", cr_en, 0);
    chk("rst_cr_src", cr_src_sel, 0);
    chk("rst_cr_rst", cr_rst, 0);
    chk("rst_din_vld", din_vld, 0);
    chk("rst_din_data", din_data, 0);
    chk("rst_tx_data", tx_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    read_sr("sr_reset", sr(1, 0, 0));

    // 1: CR write and readback
    send_byte(8'h80); send_byte(8'h03);
    @(negedge clk);
    chk("cr_en_wr", cr_en, 1);
    chk("cr_src_wr", cr_src_sel, 1);
    chk("cr_rst_wr", cr_rst, 0);
    exp_tx.push_back(8'h03);
    send_byte(8'h00);
    @(negedge clk);
    chk("tx_vld_latency", tx_vld, 1);
    drain("cr_read");

    // 2: DIN assembly, top bits beyond DATA_W ignored
    exp_din.push_back(11'h5AB);
    send_byte(8'h82); send_byte(8'hAB); send_byte(8'h05);
    repeat (3) @(negedge clk);
    chk("din1_seen", exp_din.size(), 0);
    exp_din.push_back(11'h7AB);
    send_byte(8'h82); send_byte(8'hAB); send_byte(8'hFF);
    repeat (3) @(negedge clk);
    chk("din2_seen", exp_din.size(), 0);

    // 3: DOUT reads with stalls, then empty read
    push_word(11'h123); push_word(11'h456);
    rdy_mode = 1;
    exp_tx.push_back(8'h23); exp_tx.push_back(8'h01);
    send_byte(8'h03); drain("dout0");
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h04);
    send_byte(8'h03); drain("dout1");
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    send_byte(8'h03); drain("dout_empty");
    rdy_mode = 0;
    read_sr("sr_empty_err", sr(1, 0, 1));
    send_byte(8'h81);

    // 4: overflow
    for (int i = 0; i <= DOUT_DEPTH; i++) push_word(DATA_W'(11'h100 + i));
    read_sr("sr_overflow", sr(0, 1, 1));
    send_byte(8'h81);
    read_sr("sr_err_cleared", sr(0, 1, 0));
    for (int i = 0; i < DOUT_DEPTH; i++) begin
      exp_tx.push_back(8'(i)); exp_tx.push_back(8'h01);
      send_byte(8'h03); drain("dout_ovf");
    end
    read_sr("sr_drained", sr(1, 0, 0));

    // 5: inter-byte timeout
    send_byte(8'h82); send_byte(8'hAB);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    read_sr("sr_timeout", sr(1, 0, 1));
    exp_tx.push_back(8'h03);
    send_byte(8'h00); drain("cr_after_to");
    send_byte(8'h81);

    // rx byte arriving during TX is dropped and flags err
    rdy_mode = 2;
    exp_tx.push_back(sr(1, 0, 0));
    send_byte(8'h01);
    send_byte(8'h55);
    rdy_mode = 0;
    drain("rx_in_tx");
    read_sr("sr_rx_in_tx", sr(1, 0, 1));

    // 6: cr_rst pulse flushes FIFO and clears err
    push_word(11'h3FF); push_word(11'h001);
    send_byte(8'h80); send_byte(8'h04);
    @(negedge clk);
    chk("cr_rst_pulse", cr_rst, 1);
    chk("cr_en_rstwr", cr_en, 0);
    chk("cr_src_rstwr", cr_src_sel, 0);
    @(negedge clk);
    chk("cr_rst_one", cr_rst, 0);
    read_sr("sr_after_rst", sr(1, 0, 0));

    // reset in the middle of a DIN write
    send_byte(8'h80); send_byte(8'h03);
    send_byte(8'h82); send_byte(8'hAB);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cr_en", cr_en, 0);
    chk("mid_rst_din_vld", din_vld, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_din.push_back(11'h201);
    send_byte(8'h82); send_byte(8'h01); send_byte(8'h02);
    repeat (3) @(negedge clk);
    chk("din_after_rst", exp_din.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
